// File: rtl/seq_pkg.sv
// Shared definitions for the phase sequencer and the microinstruction decoder bench:
// opcode constants, sequencer state encoding and the state-to-phase decode.
package seq_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_OUT  = 4'b0011;
    localparam logic [3:0] OP_IN   = 4'b0100;
    localparam logic [3:0] OP_LOAD = 4'b0101;
    localparam logic [3:0] OP_HLT  = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_P0   = 3'd1,
        ST_P1   = 3'd2,
        ST_P2   = 3'd3,
        ST_P3   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    // Bit k is high only in state Pk; IDLE and HALT give all zeros.
    function automatic logic [3:0] phase_decode(input state_t s);
        logic [3:0] ph;
        ph = 4'b0000;
        case (s)
            ST_P0:   ph = 4'b0001;
            ST_P1:   ph = 4'b0010;
            ST_P2:   ph = 4'b0100;
            ST_P3:   ph = 4'b1000;
            default: ph = 4'b0000;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/phase_sequencer.sv
// Four-phase timing ring and instruction register feeding the microinstruction decoder,
// with run/stop, single-step, IN stall and HLT handling.
module phase_sequencer
    import seq_pkg::*;
#(
    parameter int BUS_WIDTH   = 8,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Run,
    input  logic                   Step,
    input  logic                   LoadInst,
    input  logic [BUS_WIDTH-1:0]   Bus,
    input  logic                   InReady,
    output logic                   Phase0,
    output logic                   Phase1,
    output logic                   Phase2,
    output logic                   Phase3,
    output logic                   InstrIn0,
    output logic                   InstrIn1,
    output logic                   InstrIn2,
    output logic                   InstrIn3,
    output logic                   InAck,
    output logic                   Halted,
    output logic [COUNT_WIDTH-1:0] InstrCount
);

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_single;
    logic                   w_single_next;
    logic                   w_load;
    logic [3:0]             r_opcode;
    logic [3:0]             r_phase;
    logic                   r_halted;
    logic [COUNT_WIDTH-1:0] r_count;

    // Only the opcode nibble of the bus is consumed.
    logic w_unused_bus;
    assign w_unused_bus = ^Bus[BUS_WIDTH-5:0];

    // Next-state decode, single-step flag update and opcode-load enable.
    always_comb begin
        w_next        = r_state;
        w_single_next = r_single;
        w_load        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Run) begin
                    w_next        = ST_P0;
                    w_single_next = 1'b0;
                end else if (Step) begin
                    w_next        = ST_P0;
                    w_single_next = 1'b1;
                end else begin
                    w_next        = ST_IDLE;
                end
            end
            ST_P0: w_next = ST_P1;
            ST_P1: begin
                w_next = ST_P2;
                w_load = LoadInst;
            end
            ST_P2: begin
                if (r_opcode == OP_HLT) begin
                    w_next = ST_HALT;
                end else if ((r_opcode == OP_IN) && !InReady) begin
                    w_next = ST_P2;
                end else begin
                    w_next = ST_P3;
                end
            end
            ST_P3: begin
                w_single_next = 1'b0;
                if (r_single || !Run) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_P0;
                end
            end
            ST_HALT: w_next = ST_HALT;
            default: begin
                w_next        = ST_IDLE;
                w_single_next = 1'b0;
            end
        endcase
    end

    // State, flag, opcode and counter registers; phase/halt outputs are pre-decoded from
    // the next state so they are true registers yet aligned with the state.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= ST_IDLE;
            r_single <= 1'b0;
            r_opcode <= OP_NOP;
            r_phase  <= 4'b0000;
            r_halted <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state  <= w_next;
            r_single <= w_single_next;
            r_phase  <= phase_decode(w_next);
            r_halted <= (w_next == ST_HALT);
            if (w_load) begin
                r_opcode <= Bus[BUS_WIDTH-1 -: 4];
            end
            if (r_state == ST_P3) begin
                r_count <= r_count + COUNT_WIDTH'(1);
            end
        end
    end

    assign InAck      = (r_state == ST_P2) && (r_opcode == OP_IN) && InReady;
    assign Phase0     = r_phase[0];
    assign Phase1     = r_phase[1];
    assign Phase2     = r_phase[2];
    assign Phase3     = r_phase[3];
    assign InstrIn0   = r_opcode[0];
    assign InstrIn1   = r_opcode[1];
    assign InstrIn2   = r_opcode[2];
    assign InstrIn3   = r_opcode[3];
    assign Halted     = r_halted;
    assign InstrCount = r_count;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed self-checking bench for phase_sequencer: run, step, IN stall, HLT, reset and
// counter wrap, with hand-computed expectations.
module tb_phase_sequencer;

    logic       Clock = 1'b0;
    logic       Reset, Run, Step, LoadInst, InReady;
    logic [7:0] Bus;
    logic       Phase0, Phase1, Phase2, Phase3;
    logic       InstrIn0, InstrIn1, InstrIn2, InstrIn3;
    logic       InAck, Halted;
    logic [7:0] InstrCount;

    int errors = 0;
    int checks = 0;

    phase_sequencer #(.BUS_WIDTH(8), .COUNT_WIDTH(8)) dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .Step(Step), .LoadInst(LoadInst),
        .Bus(Bus), .InReady(InReady),
        .Phase0(Phase0), .Phase1(Phase1), .Phase2(Phase2), .Phase3(Phase3),
        .InstrIn0(InstrIn0), .InstrIn1(InstrIn1), .InstrIn2(InstrIn2), .InstrIn3(InstrIn3),
        .InAck(InAck), .Halted(Halted), .InstrCount(InstrCount)
    );

    always #5 Clock = ~Clock;

    // Phase written P0 first: 4'b1000 means Phase0 high.
    wire [3:0] ph = {Phase0, Phase1, Phase2, Phase3};
    wire [3:0] ir = {InstrIn3, InstrIn2, InstrIn1, InstrIn0};

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [3:0] eph, input logic [3:0] eir,
                               input logic [7:0] ecnt, input logic ehalt);
        check({tag, "_phase"}, {28'd0, ph}, {28'd0, eph});
        check({tag, "_instr"}, {28'd0, ir}, {28'd0, eir});
        check({tag, "_count"}, {24'd0, InstrCount}, {24'd0, ecnt});
        check({tag, "_halted"}, {31'd0, Halted}, {31'd0, ehalt});
    endtask

    initial begin
        Reset = 1'b1; Run = 1'b0; Step = 1'b0; LoadInst = 1'b0; InReady = 1'b0; Bus = 8'h00;
        tick(); tick();
        Reset = 1'b0;
        check_state("reset", 4'b0000, 4'b0000, 8'd0, 1'b0);
        check("reset_inack", {31'd0, InAck}, 32'd0);

        // Run with LOAD 0x5A, then drop Run during P1 of an ADD.
        Run = 1'b1;
        tick(); check_state("run_p0", 4'b1000, 4'b0000, 8'd0, 1'b0);
        Bus = 8'h5A;
        tick(); check_state("run_p1", 4'b0100, 4'b0000, 8'd0, 1'b0);
        LoadInst = 1'b1;
        tick(); check_state("run_p2", 4'b0010, 4'b0101, 8'd0, 1'b0);
        LoadInst = 1'b0;
        tick(); check_state("run_p3", 4'b0001, 4'b0101, 8'd0, 1'b0);
        tick(); check_state("run_p0b", 4'b1000, 4'b0101, 8'd1, 1'b0);
        tick(); check_state("run_p1b", 4'b0100, 4'b0101, 8'd1, 1'b0);
        Run = 1'b0; LoadInst = 1'b1; Bus = 8'h10;
        tick(); check_state("drop_p2", 4'b0010, 4'b0001, 8'd1, 1'b0);
        LoadInst = 1'b0;
        tick(); check_state("drop_p3", 4'b0001, 4'b0001, 8'd1, 1'b0);
        tick(); check_state("drop_idle", 4'b0000, 4'b0001, 8'd2, 1'b0);
        tick(); check_state("drop_idle2", 4'b0000, 4'b0001, 8'd2, 1'b0);

        // Single step of ADD; second Step during P2 must be ignored.
        Step = 1'b1;
        tick(); check_state("step_p0", 4'b1000, 4'b0001, 8'd2, 1'b0);
        Step = 1'b0;
        tick(); check_state("step_p1", 4'b0100, 4'b0001, 8'd2, 1'b0);
        LoadInst = 1'b1; Bus = 8'h1C;
        tick(); check_state("step_p2", 4'b0010, 4'b0001, 8'd2, 1'b0);
        LoadInst = 1'b0; Step = 1'b1;
        tick(); check_state("step_p3", 4'b0001, 4'b0001, 8'd2, 1'b0);
        Step = 1'b0;
        tick(); check_state("step_idle", 4'b0000, 4'b0001, 8'd3, 1'b0);
        tick(); check_state("step_idle2", 4'b0000, 4'b0001, 8'd3, 1'b0);

        // IN with InReady low for 5 cycles of P2, released on the 6th.
        Step = 1'b1;
        tick(); Step = 1'b0;
        tick(); LoadInst = 1'b1; Bus = 8'h40; InReady = 1'b0;
        tick(); LoadInst = 1'b0;
        check("in_opcode", {28'd0, ir}, 32'h4);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("in_stall%0d_phase", i), {28'd0, ph}, 32'h2);
            check($sformatf("in_stall%0d_inack", i), {31'd0, InAck}, 32'd0);
            tick();
        end
        InReady = 1'b1; #1;
        check("in_release_phase", {28'd0, ph}, 32'h2);
        check("in_release_inack", {31'd0, InAck}, 32'd1);
        tick(); InReady = 1'b0; #1;
        check_state("in_p3", 4'b0001, 4'b0100, 8'd3, 1'b0);
        check("in_p3_inack", {31'd0, InAck}, 32'd0);
        tick(); check_state("in_idle", 4'b0000, 4'b0100, 8'd4, 1'b0);

        // HLT: halts after P2, ignores Run/Step, cleared only by Reset.
        Step = 1'b1;
        tick(); Step = 1'b0;
        tick(); LoadInst = 1'b1; Bus = 8'hF0;
        tick(); LoadInst = 1'b0;
        check_state("hlt_p2", 4'b0010, 4'b1111, 8'd4, 1'b0);
        tick(); check_state("hlt_halt", 4'b0000, 4'b1111, 8'd4, 1'b1);
        Run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            Step = i[0];
            tick();
            check($sformatf("hlt_hold%0d_phase", i), {28'd0, ph}, 32'h0);
            check($sformatf("hlt_hold%0d_halted", i), {31'd0, Halted}, 32'd1);
        end
        check("hlt_count_held", {24'd0, InstrCount}, 32'd4);
        Run = 1'b0; Step = 1'b0; Reset = 1'b1;
        tick(); Reset = 1'b0;
        check_state("hlt_reset", 4'b0000, 4'b0000, 8'd0, 1'b0);

        // Reset during an IN stall.
        Step = 1'b1;
        tick(); Step = 1'b0;
        tick(); LoadInst = 1'b1; Bus = 8'h4F;
        tick(); LoadInst = 1'b0;
        tick(); check("stall_phase", {28'd0, ph}, 32'h2);
        Reset = 1'b1;
        tick(); Reset = 1'b0;
        check_state("stall_reset", 4'b0000, 4'b0000, 8'd0, 1'b0);
        check("stall_reset_inack", {31'd0, InAck}, 32'd0);
        InReady = 1'b1; #1;
        check("idle_inready_inack", {31'd0, InAck}, 32'd0);
        InReady = 1'b0;

        // 256 NOPs back-to-back: counter wraps 255 -> 0, ring stays one-hot.
        Run = 1'b1;
        tick();
        for (int k = 0; k < 255; k++) begin
            for (int j = 0; j < 4; j++) begin
                if ($countones(ph) != 1) begin
                    check("wrap_onehot", {28'd0, ph}, 32'h8);
                end
                tick();
            end
        end
        check_state("wrap_255", 4'b1000, 4'b0000, 8'd255, 1'b0);
        tick(); tick(); tick(); tick();
        check_state("wrap_0", 4'b1000, 4'b0000, 8'd0, 1'b0);
        Run = 1'b0;
        tick(); tick(); tick(); tick();
        check_state("wrap_idle", 4'b0000, 4'b0000, 8'd1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
